// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Sequential scan controller for the 31:1 selector mux. It walks the mux
// select across all inputs, captures one mux output per cycle into a packed
// frame, then holds that frame on a valid/ready handshake until it is taken.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high reset
//   start         scan request, only looked at while idle
//   sel           registered mux select (never drives NUM_INP..31)
//   mux_out       combinational mux output for the current sel
//   busy          high while scanning or holding a frame
//   frame_data    packed frame, slot i at [W*i +: W]
//   frame_valid   frame_data complete and frozen
//   frame_ready   downstream accept, qualified by frame_valid
//   frame_count   accepted frames, 8-bit wrap
//   frame_parity  XOR of all frame bits (only with MUX_SCAN_PARITY_EN)
//
// Build option: define MUX_SCAN_PARITY_EN to add the frame_parity port.
//
// state | meaning
// IDLE  | waiting for start, sel parked at 0
// SCAN  | one slot captured per cycle, sel = slot being captured
// HOLD  | frame complete, frame_valid high until frame_ready

module mux_scan_ctrl #(
   parameter int NUM_INP = 31,
   parameter int W       = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [4:0]           sel,
   input  logic [W-1:0]         mux_out,
   output logic                 busy,
   output logic [NUM_INP*W-1:0] frame_data,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [7:0]           frame_count
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic                 frame_parity
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [4:0] LAST_SEL = 5'(NUM_INP - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [4:0]             sel_nxt;
   logic                   last_slot;
   logic                   accept;
   logic [NUM_INP*W-1:0]   frame_cap;

   assign last_slot = (sel == LAST_SEL);
   assign accept    = (state == ST_HOLD) && frame_ready;

   // Frame as it will look after this cycle's capture; the parity on the
   // HOLD-entry edge must include the last slot captured on that same edge.
   always_comb begin
      frame_cap = frame_data;
      for (int i = 0; i < NUM_INP; i++) begin
         if (sel == 5'(i)) begin
            frame_cap[W*i +: W] = mux_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         sel          <= 5'd0;
         frame_data   <= '0;
         frame_count  <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
         frame_parity <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         if (state == ST_SCAN) begin
            frame_data <= frame_cap;
         end
         if (accept) begin
            frame_count <= frame_count + 8'd1;
         end
`ifdef MUX_SCAN_PARITY_EN
         if ((state == ST_SCAN) && last_slot) begin
            frame_parity <= ^frame_cap;
         end
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      case (state)
         ST_IDLE: begin
            sel_nxt = 5'd0;
            if (start) begin
               state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (last_slot) begin
               state_nxt = ST_HOLD;
               sel_nxt   = 5'd0;
            end else begin
               sel_nxt = sel + 5'd1;
            end
         end
         ST_HOLD: begin
            sel_nxt = 5'd0;
            if (frame_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            sel_nxt   = 5'd0;
         end
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      frame_valid = 1'b0;
      case (state)
         ST_SCAN: busy = 1'b1;
         ST_HOLD: begin
            busy        = 1'b1;
            frame_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
